// File: rtl/imem_sync_prog_if.sv
// Fetch and programming bus for the synchronous instruction memory.
// The fetch stage and the loader drive the master side; the memory drives the slave side.
interface imem_sync_prog_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 8
);
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              addr_err;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic              ready;

   modport master (
      output fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
      input  instr, instr_valid, addr_err, ready
   );

   modport slave (
      input  fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
      output instr, instr_valid, addr_err, ready
   );
endinterface

// File: rtl/imem_sync_prog.sv
// Runtime-programmable instruction memory with a registered 1-cycle fetch port.
// After reset a clear sequence fills every word with NOP_WORD before the ports open.
module imem_sync_prog #(
   parameter int unsigned       DATA_W     = 16,
   parameter int unsigned       ADDR_W     = 8,
   parameter int unsigned       DEPTH      = 256,
   parameter logic [DATA_W-1:0] NOP_WORD   = 16'h0000,
   parameter int unsigned       INIT_CLEAR = 1
) (
   input  logic              clk,
   input  logic              rst,
   imem_sync_prog_if.slave   bus
);
   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DepthW  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] LastCnt = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {StClear, StReady} state_e;
   localparam state_e RstState = (INIT_CLEAR != 0) ? StClear : StReady;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic              instr_valid_q, addr_err_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              ready, clr_we;
   logic              fetch_acc, fetch_in_range;
   logic              prog_acc;
   logic              mem_we;
   logic [IdxW-1:0]   mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RstState;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == StClear) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == LastCnt) state_d = StReady;
      end
   end

   // FSM outputs
   always_comb begin
      ready  = 1'b0;
      clr_we = 1'b0;
      unique case (state_q)
         StClear: clr_we = 1'b1;
         StReady: ready  = 1'b1;
         default: ;
      endcase
   end

   assign fetch_acc      = bus.fetch_req & ready;
   assign fetch_in_range = {1'b0, bus.fetch_addr} < DepthW;
   assign prog_acc       = bus.prog_we & ready & ({1'b0, bus.prog_addr} < DepthW);

   // Single write port shared by the clear sequence and the programming port
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = bus.prog_addr[IdxW-1:0];
      mem_wdata = bus.prog_data;
      if (clr_we) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q[IdxW-1:0];
         mem_wdata = NOP_WORD;
      end else if (prog_acc) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_comb begin
      instr_d = instr_q;
      if (fetch_acc) instr_d = fetch_in_range ? mem[bus.fetch_addr[IdxW-1:0]] : NOP_WORD;
   end

   // Read samples the old word, so a same-cycle write to the fetched address is not seen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q       <= NOP_WORD;
         instr_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         instr_q       <= instr_d;
         instr_valid_q <= fetch_acc;
         addr_err_q    <= fetch_acc & ~fetch_in_range;
      end
   end

   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.addr_err    = addr_err_q;
   assign bus.ready       = ready;
endmodule

// File: tb/tb_imem_sync_prog.sv
// Scoreboard bench for imem_sync_prog: a reference memory predicts each fetch result,
// which is queued on acceptance and compared when instr_valid appears.
module tb_imem_sync_prog;
   localparam int unsigned DW  = 16;
   localparam int unsigned AW  = 5;
   localparam int unsigned DEP = 16;
   localparam logic [DW-1:0] NOP = 16'hF000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   imem_sync_prog_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   imem_sync_prog #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NOP_WORD(NOP), .INIT_CLEAR(1)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   logic [DW-1:0] model [DEP];
   logic          rdy_m = 1'b0;
   logic [DW:0]   sb [$];   // {addr_err, instr}

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor: one pop per valid pulse
   always @(negedge clk) begin
      logic [DW:0] e;
      if (bus.instr_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'(bus.instr_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check("instr", 32'(bus.instr), 32'(e[DW-1:0]));
            check("addr_err", 32'(bus.addr_err), 32'(e[DW]));
         end
      end else begin
         check("addr_err_idle", 32'(bus.addr_err), 32'd0);
      end
   end

   // Called at a negedge; applies inputs for the next rising edge, returns at the next negedge
   task automatic drive(input logic fr, input logic [AW-1:0] fa,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      bus.fetch_req  = fr;
      bus.fetch_addr = fa;
      bus.prog_we    = we;
      bus.prog_addr  = wa;
      bus.prog_data  = wd;
      if (fr && rdy_m)
         sb.push_back((fa < DEP) ? {1'b0, model[fa[3:0]]} : {1'b1, NOP});
      if (we && rdy_m && wa < DEP) model[wa[3:0]] = wd;
      @(negedge clk);
   endtask

   // Holds reset, releases it and walks the clear sequence with fetch/write traffic applied
   task automatic reset_and_clear();
      rst = 1'b1;
      rdy_m = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_instr", 32'(bus.instr), 32'(NOP));
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < DEP; i++) begin
         check("ready_clear", 32'(bus.ready), 32'd0);
         drive(1'b1, AW'(i), 1'b1, 5'd5, 16'hABCD);
      end
      check("ready_up", 32'(bus.ready), 32'd1);
      rdy_m = 1'b1;
      for (int i = 0; i < DEP; i++) model[i] = NOP;
   endtask

   initial begin
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.prog_we    = 1'b0;
      bus.prog_addr  = '0;
      bus.prog_data  = '0;
      @(negedge clk);

      // Clear sequence; first fetch of a cleared word, plus the CLEAR-time write to 5
      reset_and_clear();
      drive(1'b1, 5'd7, 1'b0, 5'd0, 16'h0);
      drive(1'b1, 5'd5, 1'b0, 5'd0, 16'h0);

      // Program then back-to-back fetch
      drive(1'b0, 5'd0, 1'b1, 5'd0, 16'h4100);
      drive(1'b0, 5'd0, 1'b1, 5'd1, 16'h4202);
      drive(1'b0, 5'd0, 1'b1, 5'd2, 16'h0321);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 16'h0);
      drive(1'b1, 5'd1, 1'b0, 5'd0, 16'h0);
      drive(1'b1, 5'd2, 1'b0, 5'd0, 16'h0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 16'h0);

      // Same-cycle write/fetch returns the old word
      drive(1'b0, 5'd0, 1'b1, 5'd3, 16'h0022);
      drive(1'b1, 5'd3, 1'b1, 5'd3, 16'h1132);
      drive(1'b1, 5'd3, 1'b0, 5'd0, 16'h0);

      // Out-of-range fetch and dropped write, then sweep every word
      drive(1'b1, 5'd20, 1'b1, 5'd20, 16'hDEAD);
      drive(1'b1, 5'd31, 1'b1, 5'd16, 16'hBEEF);
      for (int i = 0; i < DEP; i++) drive(1'b1, AW'(i), 1'b0, 5'd0, 16'h0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 16'h0);

      // Asynchronous reset in the middle of a fetch stream
      drive(1'b1, 5'd0, 1'b0, 5'd0, 16'h0);
      drive(1'b1, 5'd1, 1'b0, 5'd0, 16'h0);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      check("async_valid_drop", 32'(bus.instr_valid), 32'd0);
      check("async_ready_drop", 32'(bus.ready), 32'd0);
      @(negedge clk);
      reset_and_clear();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 16'h0);
      drive(1'b1, 5'd1, 1'b0, 5'd0, 16'h0);
      drive(1'b1, 5'd5, 1'b0, 5'd0, 16'h0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 16'h0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 16'h0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_sync_prog.md
Name: imem_sync_prog

Overview:
- Parametrised, synchronous successor to the processor's instruction memory.
- Registered 1-cycle fetch port with req/valid handshake, plus a write (programming) port so the program is loaded at runtime instead of being fixed at elaboration.
- A reset-time clear FSM fills every location with a NOP word.
- Sits between the fetch stage (PC) and decode.

Parameters:
- DATA_W, 16, instruction width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of implemented words; must be at least 1 and at most 2**ADDR_W.
- NOP_WORD, 16'h0000, word written by the clear FSM and returned for out-of-range fetches; DATA_W bits wide.
- INIT_CLEAR, 1, 1 = run the clear sequence after reset; 0 = go straight to READY with contents undefined.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  fetch request; sampled only while ready=1.
- fetch_addr  in  ADDR_W  fetch address (PC).
- instr  out  DATA_W  fetched instruction; registered.
- instr_valid  out  1  one-cycle pulse: instr holds the data for the last accepted fetch.
- addr_err  out  1  registered; asserted with instr_valid when the fetch address was ≥ DEPTH.
- prog_we  in  1  programming write enable; sampled only while ready=1.
- prog_addr  in  ADDR_W  programming address.
- prog_data  in  DATA_W  programming data.
- ready  out  1  1 = READY state; fetch and program ports are accepted.

Behaviour:
- Reset (async, while rst=1): state=CLEAR if INIT_CLEAR=1, else READY.
  - clr_cnt=0, instr=NOP_WORD, instr_valid=0, addr_err=0.
  - ready=0 in CLEAR, 1 in READY.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes NOP_WORD to mem[clr_cnt], then clr_cnt++.
  - When the write at clr_cnt=DEPTH-1 completes, go to READY on that edge; ready rises the next cycle.
  - CLEAR lasts exactly DEPTH cycles after reset deassertion.
  - fetch_req and prog_we are ignored in CLEAR: no pulse, no write.
  - READY: stays there until the next rst.
- Fetch: an accepted fetch is fetch_req=1 AND ready=1 at edge N.
  - At edge N+1... precisely: instr_valid=1 in the cycle after edge N. If fetch_addr<DEPTH, instr=mem[fetch_addr]; otherwise instr=NOP_WORD and addr_err=1.
  - Latency is exactly 1 cycle. Back-to-back fetches give one valid per cycle.
  - instr_valid=0 in any cycle that follows a non-accepted edge. addr_err=0 whenever instr_valid=0.
  - instr holds its last value until the next accepted fetch.
- Program write: prog_we=1 AND ready=1 AND prog_addr<DEPTH writes prog_data to mem[prog_addr] at the edge.
  - If prog_addr ≥ DEPTH the write is silently dropped.
- Simultaneous fetch and write to the same address in the same cycle: read-before-write. instr returns the old word; the new word is visible to the next fetch.
- Address arithmetic: clr_cnt is ADDR_W+1 bits wide, so DEPTH=2**ADDR_W does not overflow. The range check is an unsigned compare against DEPTH.
- Reset mid-CLEAR or mid-READY: the FSM restarts CLEAR from 0.
  - Any pending instr_valid is dropped immediately (async).
  - Memory is re-cleared when INIT_CLEAR=1; prior program contents are lost.
- Memory has no reset of its own; only the CLEAR sequence initialises it.

Test Plan:
- Use DEPTH=16, ADDR_W=5, NOP_WORD=16'hF000.
- Clear sequence: release rst, hold fetch_req=1 -> ready=0 for exactly 16 cycles, then ready=1. No instr_valid during CLEAR. First fetch of addr 7 returns 16'hF000 with addr_err=0.
- Program then fetch: in READY write mem[0]=16'h4100, mem[1]=16'h4202, mem[2]=16'h0321. Fetch 0,1,2 on consecutive cycles -> instr_valid high 3 cycles, instr=4100,4202,0321, each 1 cycle after its request.
- Same-cycle hazard: mem[3]=16'h0022; in one cycle write mem[3]=16'h1132 and fetch addr 3 -> instr=16'h0022. Next fetch of 3 -> 16'h1132.
- Out of range: fetch addr 20 -> instr=16'hF000, addr_err=1, instr_valid=1. Write to addr 20 is dropped; all mem[0..15] unchanged.
- Reset mid-operation: assert rst asynchronously during a stream of fetches -> instr_valid=0 immediately. After release, 16 CLEAR cycles follow, then fetching addr 0 returns 16'hF000, confirming the program was wiped.
- Inputs in CLEAR: prog_we=1 to addr 5 with 16'hABCD during CLEAR -> after ready, fetching addr 5 returns 16'hF000.
